// File: rtl/wave_warp_pkg.sv
// rtl/wave_warp_pkg.sv - shared types and constants for the wave_warp vertical-displacement warp
// Purpose: warp mode encoding, pipeline depth and the fixed shift amounts of the wave curve.
// Ports: none (package).
package wave_warp_pkg;

  typedef enum logic [1:0] {
    WARP_BYPASS,
    WARP_WAVE,
    WARP_SHEAR,
    WARP_ANIM
  } warp_mode_t;

  localparam int WARP_LATENCY = 3;
  localparam int MID_SHIFT    = 4;
  localparam int SIDE_SHIFT   = 3;

endpackage

// File: rtl/wave_warp_if.sv
// rtl/wave_warp_if.sv - pixel stream and control bundle for wave_warp
// Purpose: groups the pixel-in, mode/frame control and pixel-out signals.
// Ports: slave  = the warp block (consumes *_in, drives *_out);
//        master = the pixel source / sink side.
interface wave_warp_if #(
  parameter int PIX_W = 7,
  parameter int H_W   = 11,
  parameter int V_W   = 10
) ();

  logic [PIX_W-1:0] data_in;
  logic [H_W-1:0]   hcount_in;
  logic [V_W-1:0]   vcount_in;
  logic             data_valid_in;
  logic [1:0]       mode_in;
  logic             frame_start_in;
  logic             data_valid_out;
  logic [H_W-1:0]   hcount_out;
  logic [V_W-1:0]   vcount_out;
  logic [PIX_W-1:0] pixel_out;

  modport slave (
    input  data_in, hcount_in, vcount_in, data_valid_in, mode_in, frame_start_in,
    output data_valid_out, hcount_out, vcount_out, pixel_out
  );

  modport master (
    output data_in, hcount_in, vcount_in, data_valid_in, mode_in, frame_start_in,
    input  data_valid_out, hcount_out, vcount_out, pixel_out
  );

endinterface

// File: rtl/wave_warp_offset.sv
// rtl/wave_warp_offset.sv - stages 1-2 of the warp: column remap, offset terms, row sum
// Purpose: stage 1 remaps the column (animated mode) and forms mid/side/shear terms;
//          stage 2 selects the offset and adds it to the row.
// Ports: clk_in, rst_n_in (async, active-low); hcount_in, vcount_in, mode_in, phase_in
//        sampled together; sum_out = signed unwrapped row, two cycles later.
module wave_warp_offset
  import wave_warp_pkg::*;
#(
  parameter int WIDTH       = 240,
  parameter int H_W         = 11,
  parameter int V_W         = 10,
  parameter int SHEAR_SHIFT = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [H_W-1:0]        hcount_in,
  input  logic [V_W-1:0]        vcount_in,
  input  warp_mode_t            mode_in,
  input  logic [H_W-1:0]        phase_in,
  output logic signed [V_W+1:0] sum_out
);

  localparam int AW = H_W + 2;
  localparam int SW = V_W + 2;
  localparam logic signed [AW-1:0] CTR   = AW'(WIDTH / 2);
  localparam logic signed [AW-1:0] WID   = AW'(WIDTH);
  localparam logic [H_W:0]         WID_U = (H_W + 1)'(WIDTH);

  logic [H_W:0]         h_col;
  logic signed [AW-1:0] h_s, diff;
  logic signed [AW-1:0] mid_d, mid_q, side_d, side_q, shear_d, shear_q;
  warp_mode_t           mode_d, mode_q;
  logic [V_W-1:0]       vc_d, vc_q;
  logic signed [SW-1:0] off, sum_d, sum_q;

  // Stage 1. Animated mode is folded into plain wave here, and out-of-range
  // columns are folded into bypass, so stage 2 only sees three cases.
  always_comb begin
    h_col  = {1'b0, hcount_in};
    mode_d = mode_in;
    if (mode_in == WARP_ANIM) begin
      h_col = {1'b0, hcount_in} + {1'b0, phase_in};
      if (h_col >= WID_U) h_col = h_col - WID_U;
      mode_d = WARP_WAVE;
    end
    if ({1'b0, hcount_in} >= WID_U) mode_d = WARP_BYPASS;
    h_s     = $signed({1'b0, h_col});
    diff    = h_s - CTR;
    mid_d   = diff >>> MID_SHIFT;
    side_d  = (h_s > CTR) ? ((h_s - WID) >>> SIDE_SHIFT) : ((-h_s) >>> SIDE_SHIFT);
    shear_d = diff >>> SHEAR_SHIFT;
    vc_d    = vcount_in;
  end

  // Stage 2. |offset| < HEIGHT, so truncating to V_W+2 bits keeps the value.
  always_comb begin
    off = '0;
    case (mode_q)
      WARP_WAVE:  off = SW'(mid_q * side_q);
      WARP_SHEAR: off = SW'(shear_q);
      default:    off = '0;
    endcase
    sum_d = $signed({2'b00, vc_q}) + off;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mid_q   <= '0;
      side_q  <= '0;
      shear_q <= '0;
      mode_q  <= WARP_BYPASS;
      vc_q    <= '0;
      sum_q   <= '0;
    end else begin
      mid_q   <= mid_d;
      side_q  <= side_d;
      shear_q <= shear_d;
      mode_q  <= mode_d;
      vc_q    <= vc_d;
      sum_q   <= sum_d;
    end
  end

  assign sum_out = sum_q;

endmodule

// File: rtl/wave_warp.sv
// rtl/wave_warp.sv - 3-stage pipelined vertical-displacement warp of the pixel stream
// Purpose: holds the frame-synchronous mode and phase registers, the wrap stage and the
//          valid/hcount/pixel delay lines; offset maths lives in wave_warp_offset.
// Ports: clk_in; rst_n_in (async, active-low); bus (wave_warp_if.slave) carrying
//        data/hcount/vcount/valid in, mode_in, frame_start_in, and the delayed outputs.
// Build option: define WAVE_WARP_ANIM_EN to build the per-frame phase counter; without
//        it the phase is 0 and mode 3 behaves as mode 1.
module wave_warp
  import wave_warp_pkg::*;
#(
  parameter int HEIGHT      = 320,
  parameter int WIDTH       = 240,
  parameter int PIX_W       = 7,
  parameter int H_W         = 11,
  parameter int V_W         = 10,
  parameter int SHEAR_SHIFT = 2,
  parameter int PHASE_STEP  = 8
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  wave_warp_if.slave bus
);

  localparam int SW = V_W + 2;
  localparam int L  = WARP_LATENCY;
  localparam logic signed [SW-1:0] HGT = SW'(HEIGHT);

  warp_mode_t              mode_d, mode_q;
  logic [H_W-1:0]          phase;
  logic [L-1:0]            valid_d, valid_q;
  logic [L-1:0][H_W-1:0]   hc_d, hc_q;
  logic [L-1:0][PIX_W-1:0] pix_d, pix_q;
  logic signed [SW-1:0]    sum, wrapped;
  logic [V_W-1:0]          vout_d, vout_q;

`ifdef WAVE_WARP_ANIM_EN
  logic [H_W-1:0] phase_d, phase_q;
  logic [H_W:0]   phase_sum;

  always_comb begin
    phase_sum = {1'b0, phase_q} + (H_W + 1)'(PHASE_STEP);
    phase_d   = phase_q;
    if (bus.frame_start_in) begin
      phase_d = (phase_sum >= (H_W + 1)'(WIDTH)) ? H_W'(phase_sum - (H_W + 1)'(WIDTH))
                                                  : H_W'(phase_sum);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) phase_q <= '0;
    else           phase_q <= phase_d;
  end

  assign phase = phase_q;
`else
  assign phase = '0;
`endif

  // Mode and phase update on the edge that ends the frame-start cycle, so a
  // pixel on that same cycle is computed with the previous values.
  wave_warp_offset #(
    .WIDTH      (WIDTH),
    .H_W        (H_W),
    .V_W        (V_W),
    .SHEAR_SHIFT(SHEAR_SHIFT)
  ) u_offset (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .hcount_in(bus.hcount_in),
    .vcount_in(bus.vcount_in),
    .mode_in  (mode_q),
    .phase_in (phase),
    .sum_out  (sum)
  );

  always_comb begin
    mode_d  = bus.frame_start_in ? warp_mode_t'(bus.mode_in) : mode_q;
    valid_d = {valid_q[L-2:0], bus.data_valid_in};
    hc_d    = {hc_q[L-2:0], bus.hcount_in};
    pix_d   = {pix_q[L-2:0], bus.data_in};
    wrapped = sum;
    if (sum >= HGT)      wrapped = sum - HGT;
    else if (sum[SW-1])  wrapped = sum + HGT;
    // valid_q[L-2] is the valid bit travelling alongside the stage-2 sum.
    vout_d  = valid_q[L-2] ? V_W'(wrapped) : '0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mode_q  <= WARP_BYPASS;
      valid_q <= '0;
      hc_q    <= '0;
      pix_q   <= '0;
      vout_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      valid_q <= valid_d;
      hc_q    <= hc_d;
      pix_q   <= pix_d;
      vout_q  <= vout_d;
    end
  end

  assign bus.data_valid_out = valid_q[L-1];
  assign bus.hcount_out     = hc_q[L-1];
  assign bus.pixel_out      = pix_q[L-1];
  assign bus.vcount_out     = vout_q;

endmodule

// File: tb/tb_wave_warp.sv
// tb/tb_wave_warp.sv - self-checking bench for wave_warp against an arithmetic reference model
module tb_wave_warp;

  localparam int HEIGHT      = 320;
  localparam int WIDTH       = 240;
  localparam int PIX_W       = 7;
  localparam int H_W         = 11;
  localparam int V_W         = 10;
  localparam int SHEAR_SHIFT = 2;
  localparam int PHASE_STEP  = 60;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int errors  = 0;
  int checks  = 0;
  int m_mode  = 0;
  int m_phase = 0;

  typedef struct {
    logic             vld;
    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;
    logic [PIX_W-1:0] d;
  } exp_t;

  exp_t exp_q[$];

  wave_warp_if #(.PIX_W(PIX_W), .H_W(H_W), .V_W(V_W)) bus ();

  wave_warp #(
    .HEIGHT(HEIGHT), .WIDTH(WIDTH), .PIX_W(PIX_W), .H_W(H_W), .V_W(V_W),
    .SHEAR_SHIFT(SHEAR_SHIFT), .PHASE_STEP(PHASE_STEP)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic int fdiv(int a, int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int model_v(int mode, int phase, int h, int v);
    int hh, c, mid, side, off;
    off = 0;
    if (h < WIDTH && mode != 0) begin
      hh = (mode == 3) ? (h + phase) % WIDTH : h;
      c  = WIDTH / 2;
      if (mode == 2) begin
        off = fdiv(hh - c, 1 << SHEAR_SHIFT);
      end else begin
        mid  = fdiv(hh - c, 16);
        side = (hh > c) ? fdiv(hh - WIDTH, 8) : fdiv(-hh, 8);
        off  = mid * side;
      end
    end
    return ((v + off) % HEIGHT + HEIGHT) % HEIGHT;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic prime_queue();
    exp_t z;
    z.vld = 1'b0; z.h = '0; z.v = '0; z.d = '0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  task automatic drive_idle();
    bus.frame_start_in = 1'b0;
    bus.mode_in        = 2'd0;
    bus.data_valid_in  = 1'b0;
    bus.hcount_in      = '0;
    bus.vcount_in      = '0;
    bus.data_in        = '0;
  endtask

  task automatic step(bit fs, int md, bit vld, int h, int v, int d);
    exp_t e;
    bus.frame_start_in = fs;
    bus.mode_in        = md[1:0];
    bus.data_valid_in  = vld;
    bus.hcount_in      = h[H_W-1:0];
    bus.vcount_in      = v[V_W-1:0];
    bus.data_in        = d[PIX_W-1:0];
    e.vld = vld;
    e.h   = h[H_W-1:0];
    e.d   = d[PIX_W-1:0];
    e.v   = vld ? V_W'(model_v(m_mode, m_phase, h, v)) : '0;
    exp_q.push_back(e);
    if (fs) begin
      m_mode = md;
`ifdef WAVE_WARP_ANIM_EN
      m_phase = (m_phase + PHASE_STEP) % WIDTH;
`endif
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      chk("data_valid_out", bus.data_valid_out, e.vld);
      chk("hcount_out", bus.hcount_out, e.h);
      chk("pixel_out", bus.pixel_out, e.d);
      chk("vcount_out", bus.vcount_out, e.v);
    end
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset data_valid_out", bus.data_valid_out, 0);
    chk("reset hcount_out", bus.hcount_out, 0);
    chk("reset pixel_out", bus.pixel_out, 0);
    chk("reset vcount_out", bus.vcount_out, 0);
    rst_n   = 1'b1;
    m_mode  = 0;
    m_phase = 0;
    prime_queue();
  endtask

  task automatic random_steps(int n);
    int h;
    for (int i = 0; i < n; i++) begin
      h = ($urandom_range(0, 9) == 0) ? int'($urandom_range(WIDTH, (1 << H_W) - 1))
                                       : int'($urandom_range(0, WIDTH - 1));
      step($urandom_range(0, 19) == 0, int'($urandom_range(0, 3)),
           $urandom_range(0, 4) != 0, h, int'($urandom_range(0, HEIGHT - 1)),
           int'($urandom_range(0, (1 << PIX_W) - 1)));
    end
  endtask

  initial begin
    drive_idle();
    #2;
    do_reset();

    // Bypass after reset
    step(0, 0, 1, 60, 100, 'h55);

    // Wave mode, including wrap in both directions and the column boundaries
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 60, 100, 1);
    step(0, 0, 1, 180, 10, 2);
    step(0, 0, 1, 60, 300, 3);
    step(0, 0, 1, 0, 5, 4);
    step(0, 0, 1, 120, 0, 5);
    step(0, 0, 1, 239, 319, 6);
    step(0, 0, 1, 240, 7, 7);
    step(0, 0, 1, 2047, 318, 8);

    // Shear mode
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 200, 50, 9);
    step(0, 0, 1, 20, 10, 10);
    step(0, 0, 1, 239, 0, 11);

    // Animated wave after a second frame start
    step(1, 3, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    step(0, 3, 1, 0, 100, 12);
    step(0, 3, 1, 200, 100, 13);

    // Mode only changes on frame start; same-cycle pixel uses the old mode
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 60, 100, 14);
    step(1, 1, 1, 60, 100, 15);
    step(0, 1, 1, 60, 100, 16);

    random_steps(400);

    // Reset in the middle of a valid stream
    for (int i = 0; i < 4; i++) step(0, 0, 1, 30 + i, 200 + i, 20 + i);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset data_valid_out", bus.data_valid_out, 0);
    chk("async reset vcount_out", bus.vcount_out, 0);
    do_reset();
    step(0, 1, 1, 60, 100, 30);
    step(0, 1, 1, 180, 10, 31);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    random_steps(200);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
